// File: rtl/serial_sub4.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per cycle, LSB first.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             brw_nx;

    always_comb begin
        d      = ra[0] ^ rb[0] ^ brw;
        brw_nx = (~ra[0] & rb[0]) | (~ra[0] & brw) | (rb[0] & brw);
    end

    // ra doubles as the result register: each result bit enters at the top
    // as the consumed minuend bit leaves the bottom.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    ra  <= {d, ra[WIDTH-1:1]};
                    rb  <= {1'b0, rb[WIDTH-1:1]};
                    brw <= brw_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= {d, ra[WIDTH-1:1]};
                        bout  <= brw_nx;
`ifdef SUB_OVF_EN
                        // On the last bit ra[0]/rb[0] are the original operand MSBs.
                        ovf   <= (ra[0] != rb[0]) && (d != ra[0]);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
